// File: rtl/crd_drop_filter.sv
// Coordinate drop filter: forwards an outer coordinate only if its inner fiber is non-empty.
// Optional CRD_DROP_FILTER_STATS_EN adds a saturating dropped_count output.
module crd_drop_filter (
    input  logic        clk,
    input  logic        flush,
    input  logic        clk_en,
    input  logic        tile_en,
    input  logic [16:0] crd_in_0,
    input  logic        crd_in_0_valid,
    output logic        crd_in_0_ready,
    input  logic [16:0] crd_in_1,
    input  logic        crd_in_1_valid,
    output logic        crd_in_1_ready,
    output logic [16:0] crd_out_0,
    output logic        crd_out_0_valid,
    input  logic        crd_out_0_ready,
    output logic [16:0] crd_out_1,
    output logic        crd_out_1_valid,
    input  logic        crd_out_1_ready
`ifdef CRD_DROP_FILTER_STATS_EN
    ,
    output logic [15:0] dropped_count
`endif
);

    typedef enum logic [1:0] {StGetOuter, StWaitInner, StResolve, StDone} state_t;

    localparam logic [16:0] DoneTok = 17'h10100;

    function automatic logic f_is_stop(input logic [16:0] t);
        return t[16] && (t[9:8] == 2'b00);
    endfunction

    function automatic logic f_is_done(input logic [16:0] t);
        return t[16] && (t[9:8] == 2'b01);
    endfunction

    state_t      r_state, w_state_d;
    logic [16:0] r_hold;
    logic        r_nonempty, w_nonempty_d, w_load_hold;

    // Two 2-entry output FIFOs: index 0 feeds crd_out_0, index 1 feeds crd_out_1
    logic [16:0] r_mem [2][2];
    logic        r_rd [2];
    logic        r_wr [2];
    logic [1:0]  r_cnt [2];
    logic [1:0]  w_push, w_pop, w_full;
    logic [16:0] w_push_data [2];
    logic        w_act;

    assign w_act     = tile_en & clk_en & ~flush;
    assign w_full[0] = (r_cnt[0] == 2'd2);
    assign w_full[1] = (r_cnt[1] == 2'd2);

    assign crd_out_0       = r_mem[0][r_rd[0]];
    assign crd_out_1       = r_mem[1][r_rd[1]];
    assign crd_out_0_valid = w_act & (r_cnt[0] != 2'd0);
    assign crd_out_1_valid = w_act & (r_cnt[1] != 2'd0);
    assign w_pop[0]        = crd_out_0_valid & crd_out_0_ready;
    assign w_pop[1]        = crd_out_1_valid & crd_out_1_ready;

    always_comb begin
        w_state_d      = r_state;
        w_nonempty_d   = r_nonempty;
        w_load_hold    = 1'b0;
        w_push         = 2'b00;
        w_push_data[0] = '0;
        w_push_data[1] = '0;
        crd_in_0_ready = 1'b0;
        crd_in_1_ready = 1'b0;
        if (w_act) begin
            unique case (r_state)
                StGetOuter: begin
                    if (crd_in_0_valid) begin
                        if (f_is_stop(crd_in_0)) begin
                            crd_in_0_ready = ~w_full[0];
                            w_push[0]      = ~w_full[0];
                            w_push_data[0] = crd_in_0;
                        end else if (f_is_done(crd_in_0)) begin
                            crd_in_0_ready = 1'b1;
                            w_state_d      = StDone;
                        end else begin
                            crd_in_0_ready = 1'b1;
                            w_load_hold    = 1'b1;
                            w_nonempty_d   = 1'b0;
                            w_state_d      = StWaitInner;
                        end
                    end
                end
                StWaitInner: begin
                    if (crd_in_1_valid) begin
                        // An S_0 closing an empty fiber has no destination, so it never stalls
                        if (f_is_stop(crd_in_1) && crd_in_1[7:0] == 8'd0 && !r_nonempty) begin
                            crd_in_1_ready = 1'b1;
                            w_state_d      = StResolve;
                        end else begin
                            crd_in_1_ready = ~w_full[1];
                            w_push[1]      = ~w_full[1];
                            w_push_data[1] = crd_in_1;
                            if (!w_full[1]) begin
                                if (f_is_stop(crd_in_1) || f_is_done(crd_in_1)) begin
                                    w_state_d = StResolve;
                                end else begin
                                    w_nonempty_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                StResolve: begin
                    if (!r_nonempty) begin
                        w_state_d = StGetOuter;
                    end else if (!w_full[0]) begin
                        w_push[0]      = 1'b1;
                        w_push_data[0] = r_hold;
                        w_state_d      = StGetOuter;
                    end
                end
                StDone: begin
                    if (crd_in_1_valid) begin
                        if (f_is_done(crd_in_1)) begin
                            crd_in_1_ready = ~w_full[0] & ~w_full[1];
                            if (!w_full[0] && !w_full[1]) begin
                                w_push         = 2'b11;
                                w_push_data[0] = DoneTok;
                                w_push_data[1] = DoneTok;
                                w_state_d      = StGetOuter;
                            end
                        end else begin
                            crd_in_1_ready = ~w_full[1];
                            w_push[1]      = ~w_full[1];
                            w_push_data[1] = crd_in_1;
                        end
                    end
                end
                default: w_state_d = StGetOuter;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            r_state    <= StGetOuter;
            r_hold     <= '0;
            r_nonempty <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_rd[i]     <= 1'b0;
                r_wr[i]     <= 1'b0;
                r_cnt[i]    <= 2'd0;
                r_mem[i][0] <= '0;
                r_mem[i][1] <= '0;
            end
        end else if (clk_en) begin
            r_state    <= w_state_d;
            r_nonempty <= w_nonempty_d;
            if (w_load_hold) begin
                r_hold <= crd_in_0;
            end
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) begin
                    r_mem[i][r_wr[i]] <= w_push_data[i];
                    r_wr[i]           <= ~r_wr[i];
                end
                if (w_pop[i]) begin
                    r_rd[i] <= ~r_rd[i];
                end
                r_cnt[i] <= r_cnt[i] + {1'b0, w_push[i]} - {1'b0, w_pop[i]};
            end
        end
    end

`ifdef CRD_DROP_FILTER_STATS_EN
    logic [15:0] r_dropped;
    logic        w_drop;

    assign w_drop        = w_act && (r_state == StResolve) && !r_nonempty;
    assign dropped_count = r_dropped;

    always_ff @(posedge clk) begin
        if (flush) begin
            r_dropped <= '0;
        end else if (clk_en && w_drop && r_dropped != 16'hFFFF) begin
            r_dropped <= r_dropped + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crd_drop_filter.sv
// Randomized and directed bench for crd_drop_filter against a fiber-level reference model.
// Stats checks compile in only when CRD_DROP_FILTER_STATS_EN is defined.
module tb_crd_drop_filter;

    logic        clk = 1'b0;
    logic        flush, clk_en, tile_en;
    logic [16:0] crd_in_0, crd_in_1, crd_out_0, crd_out_1;
    logic        crd_in_0_valid, crd_in_0_ready, crd_in_1_valid, crd_in_1_ready;
    logic        crd_out_0_valid, crd_out_0_ready, crd_out_1_valid, crd_out_1_ready;
`ifdef CRD_DROP_FILTER_STATS_EN
    logic [15:0] dropped_count;
`endif

    always #5 clk = ~clk;

    crd_drop_filter u_dut (
        .clk             (clk),
        .flush           (flush),
        .clk_en          (clk_en),
        .tile_en         (tile_en),
        .crd_in_0        (crd_in_0),
        .crd_in_0_valid  (crd_in_0_valid),
        .crd_in_0_ready  (crd_in_0_ready),
        .crd_in_1        (crd_in_1),
        .crd_in_1_valid  (crd_in_1_valid),
        .crd_in_1_ready  (crd_in_1_ready),
        .crd_out_0       (crd_out_0),
        .crd_out_0_valid (crd_out_0_valid),
        .crd_out_0_ready (crd_out_0_ready),
        .crd_out_1       (crd_out_1),
        .crd_out_1_valid (crd_out_1_valid),
        .crd_out_1_ready (crd_out_1_ready)
`ifdef CRD_DROP_FILTER_STATS_EN
        ,
        .dropped_count   (dropped_count)
`endif
    );

    localparam logic [16:0] DoneTok = 17'h10100;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          total_drops = 0;
    logic [16:0] src0[$], src1[$], exp0[$], exp1[$], got0[$], got1[$];
    bit          fwd[$];
    int          exp_drops;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_stop(input logic [16:0] t);
        return t[16] && t[9:8] == 2'b00;
    endfunction

    function automatic bit is_done(input logic [16:0] t);
        return t[16] && t[9:8] == 2'b01;
    endfunction

    // Fiber-level model: walk outer tokens, consuming one inner fiber per outer coordinate
    task automatic model();
        int          j;
        bit          has, silent;
        logic [16:0] t, u;
        j = 0;
        exp0.delete(); exp1.delete(); fwd.delete();
        exp_drops = 0;
        foreach (src0[n]) begin
            t = src0[n];
            if (is_done(t)) begin
                while (j < src1.size()) begin
                    u = src1[j]; j++;
                    fwd.push_back(1'b1);
                    exp1.push_back(u);
                    if (is_done(u)) begin
                        exp0.push_back(DoneTok);
                        break;
                    end
                end
            end else if (is_stop(t)) begin
                exp0.push_back(t);
            end else begin
                has = 1'b0;
                while (j < src1.size()) begin
                    u = src1[j]; j++;
                    if (!is_stop(u) && !is_done(u)) begin
                        exp1.push_back(u);
                        fwd.push_back(1'b1);
                        has = 1'b1;
                    end else begin
                        silent = is_stop(u) && u[7:0] == 8'd0 && !has;
                        fwd.push_back(!silent);
                        if (!silent) exp1.push_back(u);
                        break;
                    end
                end
                if (has) exp0.push_back(t);
                else exp_drops++;
            end
        end
        total_drops += exp_drops;
    endtask

    function automatic logic [16:0] rnd_data();
        logic [16:0] d;
        if ($urandom_range(9) == 0) d = {1'b1, 6'($urandom), 1'b1, 1'($urandom), 8'($urandom)};
        else d = {1'b0, 16'($urandom)};
        return d;
    endfunction

    task automatic gen(input int nfib);
        src0.delete(); src1.delete();
        for (int f = 0; f < nfib; f++) begin
            if ($urandom_range(7) == 0) begin
                src0.push_back({1'b1, 6'd0, 2'b00, 8'($urandom_range(2))});
            end else begin
                src0.push_back(rnd_data());
                for (int k = 0, n = $urandom_range(3); k < n; k++) src1.push_back(rnd_data());
                src1.push_back({1'b1, 6'd0, 2'b00, 8'($urandom_range(2))});
            end
        end
        src0.push_back(DoneTok);
        for (int k = 0, n = $urandom_range(2); k < n; k++) src1.push_back(rnd_data());
        src1.push_back(DoneTok);
    endtask

    task automatic load_024();
        src0 = '{17'h00002, 17'h00005, 17'h10000, 17'h10100};
        src1 = '{17'h00001, 17'h10000, 17'h10001, 17'h10100};
    endtask

    task automatic load_025();
        src0 = '{17'h00003, 17'h00004, 17'h10000, 17'h10100};
        src1 = '{17'h10000, 17'h00007, 17'h10001, 17'h10100};
    endtask

    task automatic idle_inputs();
        crd_in_0_valid = 1'b0; crd_in_0 = '0;
        crd_in_1_valid = 1'b0; crd_in_1 = '0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1; clk_en = 1'b1; tile_en = 1'b1;
        crd_in_0_valid = 1'b1; crd_in_0 = 17'h00009;
        crd_in_1_valid = 1'b1; crd_in_1 = 17'h00008;
        crd_out_0_ready = 1'b1; crd_out_1_ready = 1'b1;
        #4;
        check("flush/handshakes", {crd_in_0_ready, crd_in_1_ready, crd_out_0_valid,
              crd_out_1_valid}, 0);
        @(negedge clk);
        flush = 1'b0;
        idle_inputs();
    endtask

    task automatic run(input int pv, input int pr, input int pce, input int stall_lo,
                       input int stall_hi, input string tag);
        int i0, i1, occ1, cyc;
        i0 = 0; i1 = 0; occ1 = 0; cyc = 0;
        got0.delete(); got1.delete();
        while (!(i0 == src0.size() && i1 == src1.size() && got0.size() == exp0.size() &&
                 got1.size() == exp1.size()) && cyc < 5000) begin
            @(negedge clk);
            crd_in_0_valid  = (i0 < src0.size()) && ($urandom_range(99) < pv);
            crd_in_0        = (i0 < src0.size()) ? src0[i0] : '0;
            crd_in_1_valid  = (i1 < src1.size()) && ($urandom_range(99) < pv);
            crd_in_1        = (i1 < src1.size()) ? src1[i1] : '0;
            crd_out_0_ready = $urandom_range(99) < pr;
            crd_out_1_ready = (cyc >= stall_lo && cyc <= stall_hi) ? 1'b0
                              : ($urandom_range(99) < pr);
            clk_en          = $urandom_range(99) < pce;
            #4;
            if (crd_in_1_valid && occ1 >= 2 && fwd[i1])
                check({tag, "/in1_ready_when_full"}, 32'(crd_in_1_ready), 0);
            if (clk_en && crd_in_0_valid && crd_in_0_ready) i0++;
            if (clk_en && crd_in_1_valid && crd_in_1_ready) begin
                if (fwd[i1]) occ1++;
                i1++;
            end
            if (clk_en && crd_out_0_valid && crd_out_0_ready) got0.push_back(crd_out_0);
            if (clk_en && crd_out_1_valid && crd_out_1_ready) begin
                got1.push_back(crd_out_1);
                occ1--;
            end
            if (occ1 > 2 || occ1 < 0) check({tag, "/out1_occupancy"}, 32'(occ1), 2);
            cyc++;
        end
        check({tag, "/timeout"}, 32'(cyc < 5000), 1);
        idle_inputs();
        clk_en = 1'b1; crd_out_0_ready = 1'b1; crd_out_1_ready = 1'b1;
        repeat (3) @(negedge clk);
        #4;
        check({tag, "/no_extra_out"}, {crd_out_0_valid, crd_out_1_valid}, 0);
        check({tag, "/out0_count"}, got0.size(), exp0.size());
        check({tag, "/out1_count"}, got1.size(), exp1.size());
        foreach (exp0[i])
            check($sformatf("%s/out0[%0d]", tag, i),
                  (i < got0.size()) ? 32'(got0[i]) : 32'hDEADBEEF, exp0[i]);
        foreach (exp1[i])
            check($sformatf("%s/out1[%0d]", tag, i),
                  (i < got1.size()) ? 32'(got1[i]) : 32'hDEADBEEF, exp1[i]);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        flush = 1'b1; clk_en = 1'b1; tile_en = 1'b1;
        idle_inputs();
        crd_out_0_ready = 1'b0; crd_out_1_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_flush();
        #4;
        check("reset/valids_after", {crd_out_0_valid, crd_out_1_valid}, 0);

        load_024(); model(); run(100, 100, 100, -1, -1, "mixed");
        load_025(); model(); run(100, 100, 100, -1, -1, "s0_suppress");
        load_024(); model(); run(100, 100, 100, 3, 8, "backpressure");

        // Minimum latency: a stop accepted at one edge is visible the next cycle
        do_flush();
        crd_out_0_ready = 1'b0; crd_out_1_ready = 1'b0;
        crd_in_0_valid = 1'b1; crd_in_0 = 17'h10000;
        #4;
        check("latency/in0_ready", 32'(crd_in_0_ready), 1);
        @(negedge clk);
        crd_in_0_valid = 1'b0;
        #4;
        check("latency/out0_valid", 32'(crd_out_0_valid), 1);
        check("latency/out0_data", 32'(crd_out_0), 32'h10000);

        // Block disabled: nothing moves and the queued stop survives
        @(negedge clk);
        tile_en = 1'b0;
        crd_in_0_valid = 1'b1; crd_in_0 = 17'h10001;
        crd_in_1_valid = 1'b1; crd_in_1 = 17'h00001;
        crd_out_0_ready = 1'b1; crd_out_1_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #4;
            check($sformatf("tile_off/c%0d", c), {crd_in_0_ready, crd_in_1_ready,
                  crd_out_0_valid, crd_out_1_valid}, 0);
            @(negedge clk);
        end
        tile_en = 1'b1;
        idle_inputs();
        #4;
        check("tile_on/out0_valid", 32'(crd_out_0_valid), 1);
        check("tile_on/out0_data", 32'(crd_out_0), 32'h10000);
        @(negedge clk);
        #4;
        check("tile_on/drained", {crd_out_0_valid, crd_out_1_valid}, 0);

        // Flush while waiting on an inner fiber with a token queued on out1
        do_flush();
        crd_out_0_ready = 1'b0; crd_out_1_ready = 1'b0;
        crd_in_0_valid = 1'b1; crd_in_0 = 17'h00002;
        @(negedge clk);
        idle_inputs();
        crd_in_1_valid = 1'b1; crd_in_1 = 17'h00001;
        @(negedge clk);
        idle_inputs();
        #4;
        check("midflush/out1_before", 32'(crd_out_1_valid), 1);
        @(negedge clk);
        flush = 1'b1;
        crd_in_1_valid = 1'b1; crd_in_1 = 17'h10000;
        #4;
        check("midflush/during", {crd_in_0_ready, crd_in_1_ready, crd_out_0_valid,
              crd_out_1_valid}, 0);
        @(negedge clk);
        flush = 1'b0;
        idle_inputs();
        #4;
        check("midflush/after", {crd_in_0_ready, crd_in_1_ready, crd_out_0_valid,
              crd_out_1_valid}, 0);
        load_024(); model(); run(100, 100, 100, -1, -1, "after_flush");

        for (int r = 0; r < 6; r++) begin
            gen($urandom_range(4, 14));
            model();
            run($urandom_range(40, 100), $urandom_range(30, 100), $urandom_range(70, 100),
                -1, -1, $sformatf("rand%0d", r));
        end

`ifdef CRD_DROP_FILTER_STATS_EN
        do_flush();
        check("stats/cleared", 32'(dropped_count), 0);
        load_025(); model(); run(100, 100, 100, -1, -1, "stats_a");
        load_025(); model(); run(100, 100, 100, -1, -1, "stats_b");
        check("stats/two_drops", 32'(dropped_count), 2);
        do_flush();
        check("stats/flushed", 32'(dropped_count), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/crd_drop_filter.md
CRD_DROP_FILTER -- requirements
Module: crd_drop_filter

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge, gated by clk_en.
REQ-002 SHALL have port: flush  in  1  reset; synchronous, active-high.
REQ-003 SHALL have ports: clk_en  in  1  clock enable; tile_en  in  1  block enable.
REQ-004 SHALL have ports: crd_in_0 / _valid / _ready  in/in/out  17/1/1  outer coordinate stream.
REQ-005 SHALL have ports: crd_in_1 / _valid / _ready  in/in/out  17/1/1  inner coordinate stream.
REQ-006 SHALL have ports: crd_out_0 / _valid / _ready  out/out/in  17/1/1  filtered outer stream; feeds the intersect/union unit's coord_in_0.
REQ-007 SHALL have ports: crd_out_1 / _valid / _ready  out/out/in  17/1/1  filtered inner stream.
REQ-008 SHALL use this token format:
- bit16=0: data, value in bits[15:0].
- bit16=1, bits[9:8]=00: stop token S_k, with level k in bits[7:0].
- bit16=1, bits[9:8]=01: done token (0x10100).
- Any other control encoding: treated as data.

Function
REQ-009 SHALL transfer a token only when valid and ready are both 1 in the same cycle.
REQ-010 SHALL buffer each output in a 2-entry FIFO; valid = FIFO non-empty; an accepted input appears at the output 1 cycle later (minimum latency 1).
REQ-011 SHALL implement states GET_OUTER, WAIT_INNER, RESOLVE, DONE.
REQ-012 GET_OUTER: crd_in_1_ready=0. Action on the outer head token:
- Stop token: forward to out0 if space, stay in GET_OUTER.
- Data: latch into hold register, clear nonempty flag, go to WAIT_INNER.
- Done: go to DONE.
REQ-013 WAIT_INNER: crd_in_0_ready=0. Action on the inner head token:
- Data: forward to out1, set nonempty.
- S_0: forward only if nonempty, else consume silently; go to RESOLVE.
- S_k (k>=1): always forward; go to RESOLVE.
REQ-014 RESOLVE: if nonempty, push the held coordinate to out0 (wait for FIFO space); if empty, drop it; go to GET_OUTER. Either branch takes one cycle when space exists.
REQ-015 DONE: accept inner tokens until the inner done token arrives, push 0x10100 to both outputs (each when space), then go to GET_OUTER. Inner data arriving in DONE is forwarded.
REQ-016 SHALL keep every input ready at 0 while the destination FIFO for that token is full; no token SHALL be lost or duplicated under backpressure.
REQ-017 With tile_en=0: all readies and valids SHALL be 0 and state SHALL hold.
REQ-018 With clk_en=0: all registers and FIFOs SHALL hold.
REQ-019 Tokens SHALL pass unmodified (no arithmetic); per-stream order SHALL be preserved.

Reset
REQ-020 With flush=1 at a clock edge, the block SHALL enter GET_OUTER, empty both FIFOs, clear the hold register and nonempty flag, and drive all valids and readies to 0 in that cycle. This applies in any state, including mid-fiber.
REQ-021 The first cycle after flush deasserts SHALL behave as a fresh start; partial fibers are discarded.

Configuration
REQ-022 Macro CRD_DROP_FILTER_STATS_EN, when defined, SHALL add port dropped_count  out  16: count of coordinates dropped in RESOLVE.
- Saturates at 0xFFFF.
- Cleared by flush.
- Holds while clk_en=0.
REQ-023 Without the macro, the port and counter SHALL be absent and function SHALL be otherwise identical.

Verification
REQ-024 Mixed fibers: out0/out1 ready=1; outer 0x00002,0x00005,0x10000,0x10100; inner 0x00001,0x10000,0x10001,0x10100 -> out0 0x00002,0x10000,0x10100; out1 0x00001,0x10000,0x10001,0x10100.
REQ-025 Empty S_0 suppression: outer 0x00003,0x00004,0x10000,0x10100; inner 0x10000,0x00007,0x10001,0x10100 -> out0 0x00004,0x10000,0x10100; out1 0x00007,0x10001,0x10100.
REQ-026 Backpressure: REQ-024 stimulus with crd_out_1_ready=0 for cycles 3-8 -> crd_in_1_ready=0 once the out1 FIFO holds 2 tokens; final sequences identical to REQ-024.
REQ-027 Mid-fiber flush: flush=1 for one cycle while in WAIT_INNER -> next cycle both valids 0, all readies 0; a subsequent REQ-024 stream reproduces the REQ-024 output exactly.
REQ-028 Stats (macro defined): run REQ-025 twice -> dropped_count=2; flush -> 0. Also: tile_en=0 for 10 cycles with inputs valid -> all readies 0 and no output tokens.
